opb_register_bank: RTL and testbench



---
 rtl/opb_regbank_pkg.sv | 36 +++
 rtl/opb_regbank_decode.sv | 58 +++++
 rtl/opb_register_bank.sv | 152 +++++++++++++++
 tb/tb_opb_register_bank.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/opb_regbank_pkg.sv
// Shared types and helpers for the OPB register bank: beat decode, byte lanes, ack state.
package opb_regbank_pkg;

  localparam int WORD_W   = 32;
  localparam int MAX_REGS = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } ack_state_e;

  // OPB numbers byte lanes MSB-first; bit b of the result enables bits [8b+7:8b].
  function automatic logic [3:0] be_to_bytemask(input logic [0:3] be);
    logic [3:0] mask;
    for (int b = 0; b < 4; b++) begin
      mask[3-b] = be[b];
    end
    return mask;
  endfunction

  function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

  function automatic logic [WORD_W-1:0] byte_merge(input logic [WORD_W-1:0] old_w,
                                                   input logic [WORD_W-1:0] new_w,
                                                   input logic [3:0]        mask);
    logic [WORD_W-1:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) w[8*b +: 8] = new_w[8*b +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/opb_regbank_decode.sv
// Window decode and two-state ack FSM: ack one cycle after a sampled hit, never two in a row.
// Read data is captured in the sample cycle and driven onto the OR-bus only during a read ack.
module opb_regbank_decode
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0110_0300,
  parameter logic [31:0] C_HIGHADDR = 32'h0110_03FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       abus,
  input  logic              rnw,
  input  logic              select,
  input  logic [WORD_W-1:0] rd_data,
  output logic [31:0]       word_idx,
  output logic              wr_en,
  output logic              xfer_ack,
  output logic [WORD_W-1:0] rd_dbus
);

  ack_state_e        state_q, state_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              hit;

  assign hit      = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign word_idx = word_index(abus, C_BASEADDR);

  always_comb begin
    state_d = state_q;
    rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_ACK;
          if (rnw) rdata_d = rd_data;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // The master holds address and data until ack, so writes commit in the ack cycle.
  assign xfer_ack = (state_q == ST_ACK);
  assign wr_en    = xfer_ack && hit && !rnw;
  assign rd_dbus  = (xfer_ack && rnw) ? rdata_q : '0;

endmodule

// File: rtl/opb_register_bank.sv
// OPB slave with C_NUM_REGS software registers: byte-enable writes, readback, write strobes, RO slots.
// Define OPB_REGBANK_COMMIT_EN for shadow registers with an atomic commit word at index C_NUM_REGS.
module opb_register_bank
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0]              C_BASEADDR   = 32'h0110_0300,
  parameter logic [31:0]              C_HIGHADDR   = 32'h0110_03FF,
  parameter int                       C_OPB_AWIDTH = 32,
  parameter int                       C_OPB_DWIDTH = 32,
  parameter int                       C_NUM_REGS   = 8,
  parameter logic [C_NUM_REGS-1:0]    C_RO_MASK    = '0,
  parameter logic [C_NUM_REGS*32-1:0] C_RESET_VALS = '0,
  parameter                           C_FAMILY     = "virtex6"
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]    OPB_ABus,
  input  logic [0:3]                 OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]    OPB_DBus,
  input  logic                       OPB_RNW,
  input  logic                       OPB_select,
  input  logic                       OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]    Sl_DBus,
  output logic                       Sl_xferAck,
  output logic                       Sl_errAck,
  output logic                       Sl_retry,
  output logic                       Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0]   user_data_out,
  input  logic [C_NUM_REGS*32-1:0]   user_data_in,
  output logic [C_NUM_REGS-1:0]      user_wr_strobe
);

  localparam unused_family = C_FAMILY;

  if (C_NUM_REGS < 1 || C_NUM_REGS > MAX_REGS) begin : g_bad_num_regs
    $error("C_NUM_REGS out of range");
  end

  logic [31:0]           word_idx;
  logic                  wr_en;
  logic [WORD_W-1:0]     wr_data, rd_data, rd_dbus;
  logic [3:0]            byte_mask;
  logic [WORD_W-1:0]     regs_q [C_NUM_REGS];
  logic [WORD_W-1:0]     regs_d [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] strobe_q, strobe_d;
  logic                  unused_seq;

  assign unused_seq = OPB_seqAddr;
  assign wr_data    = OPB_DBus;
  assign byte_mask  = be_to_bytemask(OPB_BE);

  opb_regbank_decode #(
    .C_BASEADDR(C_BASEADDR),
    .C_HIGHADDR(C_HIGHADDR)
  ) u_decode (
    .clk     (OPB_Clk),
    .rst     (OPB_Rst),
    .abus    (OPB_ABus),
    .rnw     (OPB_RNW),
    .select  (OPB_select),
    .rd_data (rd_data),
    .word_idx(word_idx),
    .wr_en   (wr_en),
    .xfer_ack(Sl_xferAck),
    .rd_dbus (rd_dbus)
  );

`ifdef OPB_REGBANK_COMMIT_EN
  logic [WORD_W-1:0]     shadow_q [C_NUM_REGS];
  logic [WORD_W-1:0]     shadow_d [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] dirty_q, dirty_d;

  always_comb begin
    regs_d   = regs_q;
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
    strobe_d = '0;
    if (wr_en && (word_idx == 32'(C_NUM_REGS))) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (dirty_q[i]) regs_d[i] = shadow_q[i];
      end
      strobe_d = dirty_q;
      dirty_d  = '0;
    end
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (wr_en && !C_RO_MASK[i] && (word_idx == 32'(i))) begin
        shadow_d[i] = byte_merge(shadow_q[i], wr_data, byte_mask);
        dirty_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) shadow_q[i] <= C_RESET_VALS[32*i +: 32];
      dirty_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
    end
  end
`else
  always_comb begin
    regs_d   = regs_q;
    strobe_d = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (wr_en && !C_RO_MASK[i] && (word_idx == 32'(i))) begin
        regs_d[i]   = byte_merge(regs_q[i], wr_data, byte_mask);
        strobe_d[i] = 1'b1;
      end
    end
  end
`endif

  // RO slots are never written, so their output stays at the reset value.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) regs_q[i] <= C_RESET_VALS[32*i +: 32];
      strobe_q <= '0;
    end else begin
      regs_q   <= regs_d;
      strobe_q <= strobe_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (word_idx == 32'(i)) begin
`ifdef OPB_REGBANK_COMMIT_EN
        rd_data = C_RO_MASK[i] ? user_data_in[32*i +: 32] : shadow_q[i];
`else
        rd_data = C_RO_MASK[i] ? user_data_in[32*i +: 32] : regs_q[i];
`endif
      end
    end
`ifdef OPB_REGBANK_COMMIT_EN
    if (word_idx == 32'(C_NUM_REGS)) rd_data = WORD_W'(dirty_q);
`endif
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = regs_q[g];
  end

  assign user_wr_strobe = strobe_q;
  assign Sl_DBus        = rd_dbus;
  assign Sl_errAck      = 1'b0;
  assign Sl_retry       = 1'b0;
  assign Sl_toutSup     = 1'b0;

endmodule

// File: tb/tb_opb_register_bank.sv
// Directed bench for opb_register_bank against a word-level register model; honours OPB_REGBANK_COMMIT_EN.
`timescale 1ns/1ps
module tb_opb_register_bank;

  localparam logic [31:0]      BASE = 32'h0110_0300;
  localparam logic [31:0]      TOP  = 32'h0110_03FF;
  localparam int               NREG = 8;
  localparam logic [NREG-1:0]  RO   = 8'h04;
  localparam logic [NREG*32-1:0] RV = {32'h0, 32'h0, 32'h0000_0005, 32'h0,
                                       32'hDEAD_BEEF, 32'h0000_2222, 32'hAAAA_AAAA, 32'h0};
  localparam logic [NREG*32-1:0] UDIN = {32'hC0DE_0007, 32'hC0DE_0006, 32'hC0DE_0005, 32'hC0DE_0004,
                                         32'hC0DE_0003, 32'h0000_0055, 32'hC0DE_0001, 32'hC0DE_0000};
`ifdef OPB_REGBANK_COMMIT_EN
  localparam bit COMMIT = 1'b1;
`else
  localparam bit COMMIT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [0:31]       opb_abus, opb_dbus;
  logic [0:3]        opb_be;
  logic              opb_rnw, opb_select, opb_seq;
  logic [0:31]       sl_dbus;
  logic              sl_xferack, sl_errack, sl_retry, sl_toutsup;
  logic [NREG*32-1:0] user_data_out;
  logic [NREG-1:0]   user_wr_strobe;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  logic [31:0]       out_m [NREG];
  logic [31:0]       sh_m  [NREG];
  logic [NREG-1:0]   dirty_m;
  logic [NREG-1:0]   strb_m;
  int                strb_cyc;
  logic [NREG*32-1:0] exp_out_v;
  logic [31:0]       rd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  opb_register_bank #(
    .C_BASEADDR  (BASE),
    .C_HIGHADDR  (TOP),
    .C_OPB_AWIDTH(32),
    .C_OPB_DWIDTH(32),
    .C_NUM_REGS  (NREG),
    .C_RO_MASK   (RO),
    .C_RESET_VALS(RV),
    .C_FAMILY    ("virtex6")
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (rst),
    .OPB_ABus      (opb_abus),
    .OPB_BE        (opb_be),
    .OPB_DBus      (opb_dbus),
    .OPB_RNW       (opb_rnw),
    .OPB_select    (opb_select),
    .OPB_seqAddr   (opb_seq),
    .Sl_DBus       (sl_dbus),
    .Sl_xferAck    (sl_xferack),
    .Sl_errAck     (sl_errack),
    .Sl_retry      (sl_retry),
    .Sl_toutSup    (sl_toutsup),
    .user_data_out (user_data_out),
    .user_data_in  (UDIN),
    .user_wr_strobe(user_wr_strobe)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      out_m[i] = RV[32*i +: 32];
      sh_m[i]  = RV[32*i +: 32];
    end
    dirty_m  = '0;
    strb_m   = '0;
    strb_cyc = -1;
  endtask

  // One beat, entered and left 1ns after a rising edge; checks ack timing and read data.
  task automatic xfer(input string name, input logic [31:0] addr, input bit rnw,
                      input logic [0:3] be, input logic [31:0] data, output logic [31:0] rdata);
    bit          hit;
    int          idx;
    logic [31:0] exp_rd, m;
    hit    = (addr >= BASE) && (addr <= TOP);
    idx    = hit ? int'((addr - BASE) >> 2) : -1;
    exp_rd = '0;
    if (hit && idx < NREG) exp_rd = RO[idx] ? UDIN[32*idx +: 32] : (COMMIT ? sh_m[idx] : out_m[idx]);
    else if (hit && COMMIT && idx == NREG) exp_rd = 32'(dirty_m);
    opb_abus = addr; opb_rnw = rnw; opb_be = be; opb_dbus = data; opb_select = 1'b1;
    @(negedge clk);
    chk({name, " early ack"}, sl_xferack, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk({name, " ack"}, sl_xferack, hit);
    if (hit && rnw) chk({name, " rdata"}, sl_dbus, exp_rd);
    rdata = sl_dbus;
    @(posedge clk);
    #1;
    opb_select = 1'b0; opb_rnw = 1'b1; opb_dbus = '0; opb_be = '0;
    if (hit && !rnw) begin
      if (idx < NREG && !RO[idx]) begin
        m = COMMIT ? sh_m[idx] : out_m[idx];
        for (int b = 0; b < 4; b++) if (be[b]) m[31-8*b -: 8] = data[31-8*b -: 8];
        if (COMMIT) begin
          sh_m[idx] = m;
          dirty_m[idx] = 1'b1;
        end else begin
          out_m[idx] = m;
          strb_m     = NREG'(1) << idx;
          strb_cyc   = cyc;
        end
      end else if (COMMIT && idx == NREG) begin
        for (int i = 0; i < NREG; i++) if (dirty_m[i]) out_m[i] = sh_m[i];
        strb_m   = dirty_m;
        strb_cyc = cyc;
        dirty_m  = '0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NREG; i++) exp_out_v[32*i +: 32] = out_m[i];
      chk("user_data_out", user_data_out, exp_out_v);
      chk("user_wr_strobe", user_wr_strobe, (cyc == strb_cyc) ? strb_m : '0);
      if (!sl_xferack || !opb_rnw) chk("Sl_DBus idle", sl_dbus, '0);
      chk("tied outputs", {sl_errack, sl_retry, sl_toutsup}, 3'b000);
    end
  end

  initial begin
    rst = 1'b1; opb_select = 1'b0; opb_abus = '0; opb_rnw = 1'b1;
    opb_be = '0; opb_dbus = '0; opb_seq = 1'b0;
    model_reset();
    @(posedge clk); #1; chk_en = 1'b1;
    @(negedge clk);
    chk("reset ack", sl_xferack, 1'b0);
    chk("reset dbus", sl_dbus, '0);
    chk("reset strobe", user_wr_strobe, '0);
    chk("reset reg3 out", user_data_out[127:96], 32'hDEAD_BEEF);
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;

    xfer("rd reg3", BASE + 32'h0C, 1'b1, 4'b1111, '0, rd);
    chk("reg3 literal", rd, 32'hDEAD_BEEF);

    xfer("wr reg1", BASE + 32'h04, 1'b0, 4'b1001, 32'h1234_5678, rd);
`ifdef OPB_REGBANK_COMMIT_EN
    chk("reg1 out held", user_data_out[63:32], 32'hAAAA_AAAA);
`else
    chk("reg1 out literal", user_data_out[63:32], 32'h12AA_AA78);
    chk("reg1 strobe literal", user_wr_strobe, 8'h02);
`endif
    xfer("rd reg1 b2b", BASE + 32'h04, 1'b1, 4'b1111, '0, rd);
    chk("reg1 readback literal", rd, 32'h12AA_AA78);

    xfer("wr ro reg2", BASE + 32'h08, 1'b0, 4'b1111, 32'hFFFF_FFFF, rd);
    chk("ro reg2 out literal", user_data_out[95:64], 32'h0000_2222);
    xfer("rd ro reg2", BASE + 32'h08, 1'b1, 4'b1111, '0, rd);
    chk("ro reg2 readback literal", rd, 32'h0000_0055);

    xfer("rd unimpl", 32'h0110_03F0, 1'b1, 4'b1111, '0, rd);
    chk("unimpl literal", rd, 32'h0);
    xfer("wr unimpl", 32'h0110_03F0, 1'b0, 4'b1111, 32'h1111_1111, rd);
    xfer("rd past top", 32'h0110_0400, 1'b1, 4'b1111, '0, rd);
    xfer("wr past top", 32'h0110_0400, 1'b0, 4'b1111, 32'h2222_2222, rd);
    xfer("wr below base", 32'h0110_02FC, 1'b0, 4'b1111, 32'h3333_3333, rd);

    xfer("commit flush", BASE + 32'h20, 1'b0, 4'b1111, '0, rd);
    xfer("wr reg0", BASE + 32'h00, 1'b0, 4'b1111, 32'h0000_00A0, rd);
    xfer("wr reg4", BASE + 32'h10, 1'b0, 4'b0011, 32'h4444_4444, rd);
    xfer("rd reg0", BASE + 32'h00, 1'b1, 4'b1111, '0, rd);
    chk("reg0 readback literal", rd, 32'h0000_00A0);
    xfer("rd commit word", BASE + 32'h20, 1'b1, 4'b1111, '0, rd);
`ifdef OPB_REGBANK_COMMIT_EN
    chk("dirty mask literal", rd, 32'h11);
    chk("reg4 out pre-commit", user_data_out[159:128], 32'h0);
`else
    chk("commit word as unimpl", rd, 32'h0);
`endif
    xfer("wr commit", BASE + 32'h20, 1'b0, 4'b1111, '0, rd);
`ifdef OPB_REGBANK_COMMIT_EN
    chk("commit strobe literal", user_wr_strobe, 8'h11);
`endif
    chk("reg4 out literal", user_data_out[159:128], 32'h0000_4444);
    chk("reg0 out literal", user_data_out[31:0], 32'h0000_00A0);
    xfer("rd commit after", BASE + 32'h20, 1'b1, 4'b1111, '0, rd);
    chk("dirty cleared literal", rd, 32'h0);

    xfer("wr reg5", BASE + 32'h14, 1'b0, 4'b0110, 32'h00BE_EF00, rd);
    xfer("rd reg5 b2b", BASE + 32'h14, 1'b1, 4'b1111, '0, rd);
    chk("raw reg5 literal", rd, 32'h00BE_EF05);

    // Select held for six sampled cycles.
    opb_abus = BASE + 32'h0C; opb_rnw = 1'b1; opb_be = 4'b1111; opb_select = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("held ack", sl_xferack, k % 2 == 1);
      if (k % 2 == 1) chk("held rdata", sl_dbus, 32'hDEAD_BEEF);
    end
    opb_select = 1'b0;
    @(posedge clk); #1;

    // Reset sampled together with a select: no ack may follow.
    opb_abus = BASE + 32'h0C; opb_rnw = 1'b1; opb_select = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; opb_select = 1'b0;
    model_reset();
    @(negedge clk);
    chk("ack after reset", sl_xferack, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("ack after reset +1", sl_xferack, 1'b0);
    chk("reg1 reset literal", user_data_out[63:32], 32'hAAAA_AAAA);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
